// File: rtl/pic_pkg.sv
// Shared definitions for the PIC command/register block: sequencer states,
// command-word bit positions and EOI command codes.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_e;

    // ICW1 fields
    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_INIT = 4;

    // ICW4 fields
    localparam int ICW4_AEOI = 1;

    // OCW2 fields (command in [7:5], level in [2:0])
    localparam int OCW2_CMD_LSB = 5;
    localparam int OCW2_LVL_LSB = 0;

    // OCW3 fields; bit 3 set with bit 4 clear selects OCW3 over OCW2
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SEL  = 3;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

    // OCW2 EOI command codes
    localparam logic [2:0] EOI_ROT_AUTO_CLR = 3'b000;
    localparam logic [2:0] EOI_NONSPEC      = 3'b001;
    localparam logic [2:0] EOI_NOP          = 3'b010;
    localparam logic [2:0] EOI_SPEC         = 3'b011;
    localparam logic [2:0] EOI_ROT_AUTO_SET = 3'b100;
    localparam logic [2:0] EOI_ROT_NONSPEC  = 3'b101;
    localparam logic [2:0] EOI_SET_PRIO     = 3'b110;
    localparam logic [2:0] EOI_ROT_SPEC     = 3'b111;

endpackage

// File: rtl/pic_strobe_edge.sv
// One-flop edge detector for an active-low bus strobe, qualified by chip select.
// RISING=0 flags the strobe going low, RISING=1 flags it returning high.
module pic_strobe_edge #(
    parameter bit RISING = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic strobe_n,
    output logic pulse
);

    logic prev_n;

    // Remember last cycle's strobe level; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) prev_n <= 1'b1;
        else     prev_n <= strobe_n;
    end

    assign pulse = !cs_n && (RISING ? (strobe_n && !prev_n) : (!strobe_n && prev_n));

endmodule

// File: rtl/pic_cmd_regs.sv
// PIC command/register block: ICW1-ICW4 init sequencer, OCW1-OCW3 decode,
// banked interrupt mask and registered IRR/ISR/IMR read-back.
//
// Read path handshake: dout_oe is the valid qualifier for dout. There is no
// ready; the consumer (data buffer) takes dout in every cycle dout_oe is high.
// dout_oe rises the cycle after cs_n=0/rd_n=0 first holds (with no write
// accepted that cycle) and falls the cycle after that condition drops.
module pic_cmd_regs
    import pic_pkg::*;
#(
    parameter int BANKS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 wr_n,
    input  logic                 rd_n,
    input  logic                 a0,
    input  logic                 sp_n,
    input  logic [7:0]           din,
    input  logic [8*BANKS-1:0]   irr,
    input  logic [8*BANKS-1:0]   isr,
    output logic [7:0]           dout,
    output logic                 dout_oe,
    output logic                 init_done,
    output logic                 sngl,
    output logic                 ltim,
    output logic                 aeoi,
    output logic [4:0]           vec_base,
    output logic [7:0]           icw3,
    output logic [8*BANKS-1:0]   imr,
    output logic [2:0]           eoi_cmd,
    output logic [2:0]           eoi_level,
    output logic                 eoi_pulse,
    output logic                 read_isr,
    output logic                 smm,
    output logic                 poll_req,
    output logic [2:0]           dbg_state
);

    localparam int NUM_IRQ = 8 * BANKS;
    localparam int PW      = (BANKS > 1) ? $clog2(BANKS) : 1;

    pic_state_e      state;
    logic            ic4;
    logic [PW-1:0]   bank_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            wr_acc;
    logic            rd_end;
    logic            rd_cond;
    logic [NUM_IRQ-1:0] rd_sel;
    logic [7:0]      rd_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(BANKS - 1)) return '0;
        return p + 1'b1;
    endfunction

    pic_strobe_edge #(.RISING(1'b0)) u_wr_edge (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .strobe_n (wr_n),
        .pulse    (wr_acc)
    );

    pic_strobe_edge #(.RISING(1'b1)) u_rd_edge (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .strobe_n (rd_n),
        .pulse    (rd_end)
    );

    // A write accepted in the same cycle takes priority over the read.
    assign rd_cond   = !cs_n && !rd_n && !wr_acc;
    assign dbg_state = state;

    // Select the read-back source and the bank addressed by rd_ptr.
    always_comb begin
        rd_sel = irr;
        if (a0)            rd_sel = imr;
        else if (read_isr) rd_sel = isr;
        rd_data = rd_sel[{rd_ptr, 3'b000} +: 8];
    end

    // Init sequencer, command decode, configuration registers and read-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ic4       <= 1'b0;
            bank_ptr  <= '0;
            rd_ptr    <= '0;
            dout      <= 8'h00;
            dout_oe   <= 1'b0;
            init_done <= 1'b0;
            sngl      <= 1'b0;
            ltim      <= 1'b0;
            aeoi      <= 1'b0;
            vec_base  <= 5'd0;
            icw3      <= 8'h00;
            imr       <= '0;
            eoi_cmd   <= 3'd0;
            eoi_level <= 3'd0;
            eoi_pulse <= 1'b0;
            read_isr  <= 1'b0;
            smm       <= 1'b0;
            poll_req  <= 1'b0;
        end else begin
            eoi_pulse <= 1'b0;
            poll_req  <= 1'b0;
            dout_oe   <= rd_cond;
            if (rd_cond) dout <= rd_data;
            if (rd_end)  rd_ptr <= next_ptr(rd_ptr);

            if (wr_acc) begin
                rd_ptr <= '0;
                if (!a0) bank_ptr <= '0;

                if (!a0 && din[ICW1_INIT]) begin
                    // ICW1 restarts initialisation from any state.
                    state     <= ST_WAIT_ICW2;
                    ic4       <= din[ICW1_IC4];
                    sngl      <= din[ICW1_SNGL];
                    ltim      <= din[ICW1_LTIM];
                    imr       <= '0;
                    read_isr  <= 1'b0;
                    smm       <= 1'b0;
                    init_done <= 1'b0;
                    if (!din[ICW1_IC4]) aeoi <= 1'b0;
                end else if (a0) begin
                    case (state)
                        ST_WAIT_ICW2: begin
                            vec_base <= din[7:3];
                            if (sngl && !ic4) begin
                                state     <= ST_READY;
                                init_done <= 1'b1;
                            end else if (!sngl) begin
                                state <= ST_WAIT_ICW3;
                            end else begin
                                state <= ST_WAIT_ICW4;
                            end
                        end
                        ST_WAIT_ICW3: begin
                            icw3 <= sp_n ? din : {5'b00000, din[2:0]};
                            if (ic4) begin
                                state <= ST_WAIT_ICW4;
                            end else begin
                                state     <= ST_READY;
                                init_done <= 1'b1;
                            end
                        end
                        ST_WAIT_ICW4: begin
                            aeoi      <= din[ICW4_AEOI];
                            state     <= ST_READY;
                            init_done <= 1'b1;
                        end
                        ST_READY: begin
                            // OCW1: successive writes walk through the mask banks.
                            imr[{bank_ptr, 3'b000} +: 8] <= din;
                            bank_ptr <= next_ptr(bank_ptr);
                        end
                        default: ;
                    endcase
                end else if (state == ST_READY) begin
                    if (!din[OCW3_SEL]) begin
                        eoi_cmd   <= din[OCW2_CMD_LSB +: 3];
                        eoi_level <= din[OCW2_LVL_LSB +: 3];
                        eoi_pulse <= 1'b1;
                    end else begin
                        if (din[OCW3_RR])   read_isr <= din[OCW3_RIS];
                        if (din[OCW3_ESMM]) smm      <= din[OCW3_SMM];
                        if (din[OCW3_P])    poll_req <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
